// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI command arbiter.
// This package holds the FSM state encoding, the default widths and the timeout counter sizing.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    localparam int DATA_W_DEF  = 11;
    localparam int TMO_CYC_DEF = 1023;

    // Returns the number of bits needed to hold a count of cyc. The result is never less than one.
    function automatic int tmo_width(input int cyc);
        return (cyc < 2) ? 1 : $clog2(cyc + 1);
    endfunction

    localparam int TMO_W_DEF = tmo_width(TMO_CYC_DEF);

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker.
// Returns the first requester after ptr, wrapping around the ring.
module spi_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      idx,
    output logic               valid
);

    logic [IW-1:0] cand_s;

    // Search starts at ptr+1, so the last winner has the lowest priority.
    always_comb begin
        idx    = '0;
        valid  = 1'b0;
        cand_s = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = IW'((int'(ptr) + k) % NUM_REQ);
            if (!valid && req[cand_s]) begin
                valid = 1'b1;
                idx   = cand_s;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter that shares one SPI_Master between several command sources.
// It launches each transaction through new_d/d_in and tracks completion through the master's cs.
module spi_cmd_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TMO_CYC_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       err,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       new_d,
    output logic [DATA_W-1:0]          d_in,
    input  logic                       cs_in
);

    localparam int               IW       = $clog2(NUM_REQ);
    localparam int               CNT_W    = tmo_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_e         state_r, state_nx;
    logic               cs_meta_r, cs_s;
    logic [IW-1:0]      ptr_r, ptr_nx;
    logic [CNT_W-1:0]   tmo_r, tmo_nx;
    logic [IW-1:0]      pick_idx_s;
    logic               pick_valid_s;
    logic               timeout_s;
    logic               new_d_nx, err_nx, busy_nx;
    logic [NUM_REQ-1:0] ack_nx;
    logic [DATA_W-1:0]  d_in_nx;
    logic [IW-1:0]      gnt_nx;

    spi_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_r),
        .idx   (pick_idx_s),
        .valid (pick_valid_s)
    );

    // This is a two-flop synchroniser for the master's chip select, which runs off sclk. Its idle value is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_meta_r <= 1'b1;
            cs_s      <= 1'b1;
        end else begin
            cs_meta_r <= cs_in;
            cs_s      <= cs_meta_r;
        end
    end

    // The counter value is TMO_LAST in the TIMEOUT_CYC-th cycle spent in LAUNCH or ACTIVE.
    assign timeout_s = (tmo_r == TMO_LAST);

    // This block computes the next state and the next values of all registered outputs.
    always_comb begin
        state_nx = state_r;
        ptr_nx   = ptr_r;
        tmo_nx   = tmo_r;
        new_d_nx = new_d;
        d_in_nx  = d_in;
        gnt_nx   = gnt_id;
        ack_nx   = '0;
        err_nx   = 1'b0;
        busy_nx  = busy;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_nx = LAUNCH;
                    gnt_nx   = pick_idx_s;
                    d_in_nx  = req_data[int'(pick_idx_s) * DATA_W +: DATA_W];
                    new_d_nx = 1'b1;
                    busy_nx  = 1'b1;
                    tmo_nx   = '0;
                end else begin
                    new_d_nx = 1'b0;
                    busy_nx  = 1'b0;
                end
            end
            LAUNCH: begin
                tmo_nx = tmo_r + CNT_W'(1);
                if (timeout_s) begin
                    state_nx       = DONE;
                    new_d_nx       = 1'b0;
                    ack_nx[gnt_id] = 1'b1;
                    err_nx         = 1'b1;
                end else if (!cs_s) begin
                    // Drop new_d once the master is running. Otherwise it would relaunch when it returns to idle.
                    state_nx = ACTIVE;
                    new_d_nx = 1'b0;
                end else begin
                    new_d_nx = 1'b1;
                end
            end
            ACTIVE: begin
                tmo_nx   = tmo_r + CNT_W'(1);
                new_d_nx = 1'b0;
                if (timeout_s) begin
                    state_nx       = DONE;
                    ack_nx[gnt_id] = 1'b1;
                    err_nx         = 1'b1;
                end else if (cs_s) begin
                    state_nx       = DONE;
                    ack_nx[gnt_id] = 1'b1;
                end else begin
                    state_nx = ACTIVE;
                end
            end
            DONE: begin
                state_nx = IDLE;
                ptr_nx   = gnt_id;
                new_d_nx = 1'b0;
                busy_nx  = 1'b0;
            end
            default: begin
                state_nx = IDLE;
                new_d_nx = 1'b0;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // This block holds the FSM state, the round-robin pointer, the timeout counter and the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= IW'(NUM_REQ - 1);
            tmo_r   <= '0;
            new_d   <= 1'b0;
            d_in    <= '0;
            ack     <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
            gnt_id  <= '0;
        end else begin
            state_r <= state_nx;
            ptr_r   <= ptr_nx;
            tmo_r   <= tmo_nx;
            new_d   <= new_d_nx;
            d_in    <= d_in_nx;
            ack     <= ack_nx;
            err     <= err_nx;
            busy    <= busy_nx;
            gnt_id  <= gnt_nx;
        end
    end

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Self-checking bench for spi_cmd_arbiter.
// A transaction-level model is compared every cycle, and directed scenarios add literal expectations.
module tb_spi_cmd_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int DATA_W      = 11;
    localparam int TIMEOUT_CYC = 1023;
    localparam int IW          = 2;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic                      err;
    logic                      busy;
    logic [IW-1:0]             gnt_id;
    logic                      new_d;
    logic [DATA_W-1:0]         d_in;
    logic                      cs_in = 1'b1;

    logic [DATA_W-1:0] words [NUM_REQ] = '{11'h5A5, 11'h13C, 11'h2F0, 11'h7E1};
    assign req_data = {words[3], words[2], words[1], words[0]};

    always #5 clk = ~clk;

    spi_cmd_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .err      (err),
        .busy     (busy),
        .gnt_id   (gnt_id),
        .new_d    (new_d),
        .d_in     (d_in),
        .cs_in    (cs_in)
    );

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // SPI master stand-in: it lowers cs two cycles after seeing new_d, then holds cs low for 12 cycles.
    bit spi_en = 1'b1;
    int cs_fall_cyc = 0;
    int cs_rise_cyc = 0;
    initial begin : spi_stub
        int phase;
        int cnt;
        phase = 0;
        cnt   = 0;
        forever begin
            @(negedge clk);
            if (rst || !spi_en) begin
                cs_in = 1'b1; phase = 0; cnt = 0;
            end else begin
                case (phase)
                    0: if (new_d) begin phase = 1; cnt = 0; end
                    1: begin
                        cnt++;
                        if (cnt >= 2) begin cs_in = 1'b0; cs_fall_cyc = cyc; phase = 2; cnt = 0; end
                    end
                    2: begin
                        cnt++;
                        if (cnt >= 12) begin cs_in = 1'b1; cs_rise_cyc = cyc; phase = 0; end
                    end
                    default: phase = 0;
                endcase
            end
        end
    end

    // Reference model: this is a transaction view of the arbitration rules and is updated once per clock.
    logic [NUM_REQ-1:0] e_ack   = '0;
    logic               e_err   = 1'b0;
    logic               e_busy  = 1'b0;
    logic               e_new_d = 1'b0;
    logic [IW-1:0]      e_gnt   = '0;
    logic [DATA_W-1:0]  e_d_in  = '0;
    initial begin : model
        int  ptr, age, win, c;
        bit  sync1, sync2, cs_seen, launched;
        ptr = NUM_REQ - 1; age = 0; sync1 = 1'b1; sync2 = 1'b1; launched = 1'b0;
        forever begin
            @(posedge clk);
            cs_seen = sync2;
            sync2   = sync1;
            sync1   = cs_in;
            if (rst) begin
                e_ack = '0; e_err = 1'b0; e_busy = 1'b0; e_new_d = 1'b0; e_gnt = '0; e_d_in = '0;
                ptr = NUM_REQ - 1; sync1 = 1'b1; sync2 = 1'b1; age = 0; launched = 1'b0;
            end else if (e_ack != '0) begin
                ptr = int'(e_gnt); e_ack = '0; e_err = 1'b0; e_busy = 1'b0;
            end else if (!e_busy) begin
                win = -1;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    c = (ptr + k) % NUM_REQ;
                    if (win < 0 && req[IW'(c)]) win = c;
                end
                if (win >= 0) begin
                    e_gnt = IW'(win); e_d_in = words[IW'(win)];
                    e_new_d = 1'b1; e_busy = 1'b1; age = 0; launched = 1'b0;
                end
            end else begin
                age++;
                if (age >= TIMEOUT_CYC) begin
                    e_ack = '0; e_ack[e_gnt] = 1'b1; e_err = 1'b1; e_new_d = 1'b0;
                end else if (!launched && !cs_seen) begin
                    launched = 1'b1; e_new_d = 1'b0;
                end else if (launched && cs_seen) begin
                    e_ack = '0; e_ack[e_gnt] = 1'b1; e_err = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of the DUT against the model.
    initial begin : compare
        forever begin
            @(negedge clk);
            checks++;
            if ({ack, err, busy, gnt_id, new_d, d_in} === {e_ack, e_err, e_busy, e_gnt, e_new_d, e_d_in})
                passes++;
            else
                $display("FAIL model_cmp cyc %0d: dut ack=%b err=%b busy=%b gnt=%0d new_d=%b d_in=%h; model ack=%b err=%b busy=%b gnt=%0d new_d=%b d_in=%h",
                         cyc, ack, err, busy, gnt_id, new_d, d_in, e_ack, e_err, e_busy, e_gnt, e_new_d, e_d_in);
        end
    end

    // This monitor logs grant order, the spacing from ack to the next new_d, the time new_d falls, and how many cycles new_d stays high.
    int gnt_q[$];
    int spc_q[$];
    int last_ack_mon = 0;
    int nd_fall_cyc  = 0;
    int nd_hi_cnt    = 0;
    initial begin : monitor
        logic prev_nd;
        prev_nd = 1'b0;
        forever begin
            @(negedge clk);
            if (new_d && !prev_nd) begin gnt_q.push_back(int'(gnt_id)); spc_q.push_back(cyc - last_ack_mon); end
            if (!new_d && prev_nd) nd_fall_cyc = cyc;
            if (new_d) nd_hi_cnt++;
            if (ack != '0) last_ack_mon = cyc;
            prev_nd = new_d;
        end
    end

    logic [NUM_REQ-1:0] last_ack;
    logic               last_err, last_new_d;
    int                 last_ack_cyc;

    task automatic wait_acks(input int n, input bit drop, input int budget, output int got);
        got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk);
            if (ack != '0) begin
                got++; last_ack = ack; last_err = err; last_new_d = new_d; last_ack_cyc = cyc;
                if (drop) req = req & ~ack;
            end
        end
    endtask

    task automatic wait_active(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (busy && !new_d && !cs_in) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int got;
        bit ok;
        int exp2 [5] = '{0, 1, 2, 3, 0};
        int exp3 [3] = '{3, 0, 1};

        // Reset values and the first transaction.
        do_reset();
        check("rst_busy", busy, 0); check("rst_new_d", new_d, 0); check("rst_d_in", d_in, 0);
        check("rst_gnt", gnt_id, 0); check("rst_ack", ack, 0); check("rst_err", err, 0);
        req = 4'b0001;
        @(negedge clk);
        check("t1_new_d", new_d, 1); check("t1_d_in", d_in, 11'h5A5); check("t1_busy", busy, 1);
        wait_acks(1, 1'b1, 200, got);
        check("t1_acks", got, 1); check("t1_ack", last_ack, 4'b0001); check("t1_err", last_err, 0);
        check("t1_cs_rise_to_ack", last_ack_cyc - cs_rise_cyc, 3);
        check("t1_cs_fall_to_drop", nd_fall_cyc - cs_fall_cyc, 3);

        // In this test all four requesters hold continuously.
        do_reset();
        gnt_q.delete(); spc_q.delete();
        req = 4'b1111;
        wait_acks(5, 1'b0, 400, got);
        req = '0;
        check("t2_acks", got, 5); check("t2_ngrants", gnt_q.size(), 5);
        for (int i = 0; i < 5 && i < gnt_q.size(); i++) check($sformatf("t2_grant%0d", i), gnt_q[i], exp2[i]);
        if (spc_q.size() > 4) begin
            check("t2_spacing1", spc_q[1], 2); check("t2_spacing4", spc_q[4], 2);
        end else check("t2_spacing_count", spc_q.size(), 5);

        // After a grant to requester 2, the request vector becomes 1011.
        do_reset();
        req = 4'b0100;
        wait_acks(1, 1'b1, 200, got);
        check("t3_first_ack", last_ack, 4'b0100);
        gnt_q.delete();
        req = 4'b1011;
        wait_acks(3, 1'b1, 400, got);
        check("t3_acks", got, 3); check("t3_ngrants", gnt_q.size(), 3);
        for (int i = 0; i < 3 && i < gnt_q.size(); i++) check($sformatf("t3_grant%0d", i), gnt_q[i], exp3[i]);

        // Here the master is absent, so the transaction must time out.
        spi_en = 1'b0;
        do_reset();
        nd_hi_cnt = 0;
        req = 4'b0010;
        wait_acks(1, 1'b1, TIMEOUT_CYC + 50, got);
        check("t4_acks", got, 1); check("t4_ack", last_ack, 4'b0010); check("t4_err", last_err, 1);
        check("t4_new_d", last_new_d, 0); check("t4_launch_cycles", nd_hi_cnt, TIMEOUT_CYC);
        spi_en = 1'b1;

        // A reset arrives in the middle of ACTIVE.
        do_reset();
        req = 4'b0001;
        wait_active(100, ok);
        check("t5_reached_active", ok, 1);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_busy", busy, 0); check("t5_rst_new_d", new_d, 0); check("t5_rst_ack", ack, 0);
        check("t5_rst_d_in", d_in, 0); check("t5_rst_gnt", gnt_id, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        gnt_q.delete();
        wait_acks(1, 1'b1, 300, got);
        check("t5_acks", got, 1); check("t5_ack", last_ack, 4'b0001); check("t5_err", last_err, 0);
        check("t5_ngrants", gnt_q.size(), 1);

        // The request is withdrawn during ACTIVE.
        do_reset();
        gnt_q.delete();
        req = 4'b0100;
        wait_active(100, ok);
        check("t6_reached_active", ok, 1);
        req = '0;
        wait_acks(1, 1'b0, 200, got);
        check("t6_acks", got, 1); check("t6_ack", last_ack, 4'b0100);
        repeat (20) @(negedge clk);
        check("t6_ngrants", gnt_q.size(), 1); check("t6_idle", busy, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/spi_cmd_arbiter.md
# spi_cmd_arbiter

Shares one SPI_Master between NUM_REQ independent command sources. Round-robin arbitration picks one pending request, drives the master's new_d/d_in launch handshake, tracks the transaction through the master's cs output (synchronised into clk), and returns a one-cycle ack to the granted requester. Sits directly in front of SPI_Master in the same clk domain; it is the only driver of new_d and d_in.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- DATA_W, 11: command word width, equals SPI_Master d_in width
- TIMEOUT_CYC, 1023: max clk cycles spent in LAUNCH+ACTIVE before forced completion
- clk  in  1  system clock, same clock as SPI_Master
- rst  in  1  reset, asynchronous, active-high
- req  in  NUM_REQ  level request per requester, held until its ack
- req_data  in  NUM_REQ*DATA_W  command words, requester i at bits [i*DATA_W +: DATA_W], stable while req[i]=1
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
- err  out  1  one-cycle pulse coincident with ack when completion was forced by timeout
- busy  out  1  high from grant until the ack cycle inclusive
- gnt_id  out  $clog2(NUM_REQ)  index of current/last granted requester
- new_d  out  1  to SPI_Master new_d
- d_in  out  DATA_W  to SPI_Master d_in
- cs_in  in  1  from SPI_Master cs (sclk-derived, asynchronous to this logic)

## Operation
- cs_in passes through a 2-flop synchroniser (reset value 1) giving cs_s; only cs_s is used.
- States: IDLE, LAUNCH, ACTIVE, DONE.
- IDLE: if any req bit set, pick winner by round robin, capture req_data slice into d_in, set gnt_id, new_d=1, busy=1 -> LAUNCH. Else stay.
- LAUNCH: hold new_d=1 and d_in. On cs_s=0: new_d=0 -> ACTIVE (drop prevents a second launch when the master returns to idle).
- ACTIVE: new_d=0. On cs_s=1 -> DONE.
- DONE: ack[gnt_id]=1 for this cycle only; update round-robin pointer to gnt_id; busy=1 this cycle; -> IDLE (busy=0 next).
- Timeout: counter cleared on grant, increments each cycle in LAUNCH/ACTIVE; on reaching TIMEOUT_CYC: new_d=0, -> DONE with err=1 alongside ack.
- Round robin: search starts at pointer+1 modulo NUM_REQ; reset pointer = NUM_REQ-1 so requester 0 wins first.
- req changes after grant are ignored until the next IDLE evaluation; a requester still holding req in the IDLE after its ack is re-arbitrated at lowest priority.
- d_in holds its last value outside LAUNCH (no return to 0).

## Timing
- Reset values: new_d=0, d_in=0, ack=0, err=0, busy=0, gnt_id=0, state IDLE, pointer NUM_REQ-1, cs sync flops 1.
- Grant latency: req seen in IDLE cycle N -> new_d/d_in/busy valid cycle N+1.
- cs fall to new_d drop: 2 sync cycles + 1 = new_d low 3 cycles after cs_in falls; same 3-cycle latency from cs_in rise to DONE/ack.
- Minimum spacing between back-to-back grants: DONE + 1 IDLE cycle = 2 cycles from ack to next new_d.
- Simultaneous requests in IDLE: exactly one grant, RR order; no grant issued outside IDLE.
- Timeout expiry and cs_s edge in same cycle: timeout wins (err=1).
- rst mid-transaction: all outputs to reset values immediately; no ack issued for the aborted request; SPI_Master is on the same rst.

## Structure
- Package spi_arb_pkg: state enum (IDLE, LAUNCH, ACTIVE, DONE), DATA_W default constant, timeout counter width.
- One sub-module: spi_rr_pick — combinational round-robin winner from req vector and pointer, outputs winner index and valid.
- Synchroniser and FSM live in spi_cmd_arbiter.

## Test plan
- Reset then req=4'b0001, data0=11'h5A5, with SPI_Master (SYS_CLK 10 MHz, SPI_CLK 1 MHz) -> new_d high one cycle after req, mosi carries 11'h5A5 LSB first, single ack[0] 3 cycles after cs_in rises, err=0.
- req=4'b1111 held continuously, distinct data -> grants in order 0,1,2,3,0, exactly one ack per transaction, busy gaps of 1 cycle.
- After grant to 2, req=4'b1011 -> next grants 3 then 0 then 1.
- cs_in tied high (master absent), req[1]=1 -> after TIMEOUT_CYC cycles in LAUNCH, ack[1]=1 with err=1, new_d=0.
- rst pulsed while in ACTIVE with req[0] held -> outputs to reset values, no ack, after release req[0] re-granted and completes normally.
- req[2] deasserted during ACTIVE -> transaction still completes, ack[2] pulses once, no regrant of 2.
